logic_reg_arbiter: RTL and testbench

- Round-robin arbiter that shares one DATA_W-bit logic register (new_data) and its derived enable (en = new_data[0]) among N_REQ requesters.
- A winning requester's data is loaded into the register and held for HOLD_CYCLES cycles before the register can be re-granted.
- Sits between several procedural drivers and the single shared logic register/enable consumer, replacing ad-hoc multi-driver assignments.

---
 rtl/logic_reg_arbiter_pkg.sv | 28 ++
 rtl/logic_reg_arbiter_rr_pick.sv | 56 +++++
 rtl/logic_reg_arbiter.sv | 112 +++++++++++
 tb/tb_logic_reg_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/logic_reg_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// logic_arb_pkg
//
// Shared definitions for the logic register arbiter:
//   arb_state_t  - arbiter FSM encoding (ARB_IDLE, ARB_HOLD)
//   ARB_DATA_W   - default width of the shared logic register
//   ARB_MAX_REQ  - widest requester vector the onehot() helper can produce
//   onehot()     - index to one-hot conversion; callers keep the low bits
// -----------------------------------------------------------------------------
package logic_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    localparam int ARB_DATA_W  = 4;
    localparam int ARB_MAX_REQ = 32;

    // Returns a vector with only bit idx set. The result is ARB_MAX_REQ wide
    // so one helper serves every requester count; callers slice it down.
    function automatic logic [ARB_MAX_REQ-1:0] onehot(input int unsigned idx);
        logic [ARB_MAX_REQ-1:0] v;
        v = {{(ARB_MAX_REQ-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

endpackage

// File: rtl/logic_reg_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin selector. Scans req starting at ptr and moving
// upward with wrap-around; the requester at ptr has the highest priority.
//
// Ports:
//   req    in   N_REQ   request levels
//   ptr    in   PTR_W   highest-priority index (always < N_REQ)
//   any    out  1       at least one request is asserted
//   idx    out  PTR_W   index of the selected requester (0 when !any)
//   onehot out  N_REQ   one-hot form of idx (all zero when !any)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic             any,
    output logic [PTR_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic                                    found;
    logic [logic_arb_pkg::ARB_MAX_REQ-1:0]   oh_full;

    // Two passes instead of a modulo rotate: the first pass covers indices at
    // or above ptr, the second covers the wrapped part below ptr. This keeps
    // the search correct for non-power-of-two N_REQ without any arithmetic
    // that could produce an index >= N_REQ.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found = 1'b1;
                idx   = PTR_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = PTR_W'(i);
            end
        end
    end

    assign any = found;

    always_comb begin
        oh_full = logic_arb_pkg::onehot(32'(idx));
        onehot  = found ? oh_full[N_REQ-1:0] : '0;
    end

endmodule

// File: rtl/logic_reg_arbiter.sv
// -----------------------------------------------------------------------------
// logic_reg_arbiter
//
// Round-robin owner of a single shared logic register. Each grant loads the
// winner's data into new_data and holds it for HOLD_CYCLES cycles before the
// register can be re-granted.
//
// Handshake: a requester raises req[i] with req_data[i] valid and keeps both
// stable until it sees gnt[i] (a single-cycle registered pulse). req_data is
// captured only on the grant edge; after gnt the requester may drop req or
// change its data freely. Dropping req before gnt withdraws the request.
//
// Ports:
//   clk        in   1              clock, rising edge
//   rst        in   1              synchronous active-high reset
//   req        in   N_REQ          request levels
//   req_data   in   N_REQ*DATA_W   per-requester write data
//   gnt        out  N_REQ          one-hot grant pulse, registered
//   owner      out  PTR_W          index of current/last owner
//   new_data   out  DATA_W         shared register
//   data_valid out  1              hold window active
//   en         out  1              new_data[0] gated by data_valid
//   busy       out  1              FSM is in ARB_HOLD
// -----------------------------------------------------------------------------
module logic_reg_arbiter
    import logic_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]               gnt,
    output logic [$clog2(N_REQ)-1:0]       owner,
    output logic [DATA_W-1:0]              new_data,
    output logic                           data_valid,
    output logic                           en,
    output logic                           busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    // FSM state is kept as a named signal so checkers can bind to it.
    arb_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [PTR_W-1:0]   ptr;

    logic               pick_any;
    logic [PTR_W-1:0]   pick_idx;
    logic [N_REQ-1:0]   pick_oh;
    logic               arb_point;
    logic [PTR_W-1:0]   next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    // The last cycle of a hold window doubles as an arbitration point, which
    // is what lets back-to-back grants keep data_valid high with no gap.
    assign arb_point = (state == ARB_IDLE) || (cnt == '0);

    // Explicit wrap rather than modulo so the pointer never exceeds N_REQ-1
    // when N_REQ is not a power of two.
    assign next_ptr = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            cnt        <= '0;
            ptr        <= '0;
            gnt        <= '0;
            owner      <= '0;
            new_data   <= '0;
            data_valid <= 1'b0;
        end else begin
            // gnt is a pulse: cleared on every edge unless a new grant fires.
            gnt <= '0;
            if (arb_point) begin
                if (pick_any) begin
                    gnt        <= pick_oh;
                    new_data   <= req_data[pick_idx];
                    owner      <= pick_idx;
                    data_valid <= 1'b1;
                    cnt        <= CNT_W'(HOLD_CYCLES - 1);
                    state      <= ARB_HOLD;
                    ptr        <= next_ptr;
                end else begin
                    // new_data and owner deliberately keep their last values.
                    data_valid <= 1'b0;
                    state      <= ARB_IDLE;
                end
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign en   = new_data[0] & data_valid;
    assign busy = (state == ARB_HOLD);

endmodule

// File: tb/tb_logic_reg_arbiter.sv
module tb_logic_reg_arbiter;

  // Main instance: N_REQ=4, DATA_W=4, HOLD_CYCLES=2
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int H  = 2;
  localparam int EW = 2 + N + DW + 1;
  // Second instance: N_REQ=3, HOLD_CYCLES=1
  localparam int N3  = 3;
  localparam int EW3 = 2 + N3 + DW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [N-1:0]           req;
  logic [N-1:0][DW-1:0]   req_data;
  logic [N-1:0]           gnt;
  logic [1:0]             owner;
  logic [DW-1:0]          new_data;
  logic                   data_valid, en, busy;

  logic                   rst3;
  logic [N3-1:0]          req3;
  logic [N3-1:0][DW-1:0]  req_data3;
  logic [N3-1:0]          gnt3;
  logic [1:0]             owner3;
  logic [DW-1:0]          new_data3;
  logic                   data_valid3, en3, busy3;

  logic_reg_arbiter #(.N_REQ(N), .DATA_W(DW), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .owner(owner), .new_data(new_data), .data_valid(data_valid),
    .en(en), .busy(busy)
  );

  logic_reg_arbiter #(.N_REQ(N3), .DATA_W(DW), .HOLD_CYCLES(1)) dut3 (
    .clk(clk), .rst(rst3), .req(req3), .req_data(req_data3), .gnt(gnt3),
    .owner(owner3), .new_data(new_data3), .data_valid(data_valid3),
    .en(en3), .busy(busy3)
  );

  // Scoreboards: {owner, gnt, new_data, en} expected at each grant
  logic [EW-1:0]  exp_q[$];
  logic [EW3-1:0] exp3_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int o, input logic [N-1:0] g, input logic [DW-1:0] d, input logic e);
    exp_q.push_back({o[1:0], g, d, e});
  endtask

  task automatic push3(input int o, input logic [N3-1:0] g, input logic [DW-1:0] d, input logic e);
    exp3_q.push_back({o[1:0], g, d, e});
  endtask

  // Monitors: on every cycle the DUT presents a grant, pop and compare
  always @(negedge clk) begin
    if (gnt !== '0) begin
      if (exp_q.size() == 0) check("unexpected_gnt", 32'(gnt), 32'h0);
      else check("grant", 32'({owner, gnt, new_data, en}), 32'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (gnt3 !== '0) begin
      if (exp3_q.size() == 0) check("unexpected_gnt3", 32'(gnt3), 32'h0);
      else check("grant3", 32'({owner3, gnt3, new_data3, en3}), 32'(exp3_q.pop_front()));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_new_data"},   32'(new_data),   32'h0);
    check({tag, "_en"},         32'(en),         32'h0);
    check({tag, "_data_valid"}, 32'(data_valid), 32'h0);
    check({tag, "_gnt"},        32'(gnt),        32'h0);
    check({tag, "_owner"},      32'(owner),      32'h0);
    check({tag, "_busy"},       32'(busy),       32'h0);
  endtask

  // All inputs are driven on the falling edge; outputs are sampled there too.
  initial begin
    rst = 1'b1; req = '0; req_data = 'x;
    rst3 = 1'b1; req3 = '0; req_data3 = 'x;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // Single request to index 2, data 4'hB, window of 2 cycles
    rst = 1'b0;
    req_data = '0;
    req_data[2] = 4'hB;
    req = 4'b0100;
    push(2, 4'b0100, 4'hB, 1'b1);
    @(negedge clk);
    req = '0;
    req_data[2] = 4'h5;              // must not reach new_data
    check("single_dv_c1", 32'(data_valid), 32'h1);
    check("single_busy_c1", 32'(busy), 32'h1);
    @(negedge clk);
    check("single_dv_c2", 32'(data_valid), 32'h1);
    check("single_data_c2", 32'(new_data), 32'hB);
    @(negedge clk);
    check("single_dv_end", 32'(data_valid), 32'h0);
    check("single_busy_end", 32'(busy), 32'h0);
    check("single_data_kept", 32'(new_data), 32'hB);
    check("single_en_gated", 32'(en), 32'h0);
    check("single_gnt_end", 32'(gnt), 32'h0);

    // Reset to bring the pointer back to 0, then all four requesting
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_data = {4'h4, 4'h3, 4'h2, 4'h1};
    req = 4'b1111;
    push(0, 4'b0001, 4'h1, 1'b1);
    push(1, 4'b0010, 4'h2, 1'b0);
    push(2, 4'b0100, 4'h3, 1'b1);
    push(3, 4'b1000, 4'h4, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("b2b_dv", 32'(data_valid), 32'h1);
      if (k == 7) begin
        // Grant to 3 just fired: pointer wrapped, 0 wins, then 3
        req = 4'b1001;
        push(0, 4'b0001, 4'h1, 1'b1);
        push(3, 4'b1000, 4'h4, 1'b0);
      end
      if (k == 11) req = '0;
    end
    @(negedge clk);
    check("b2b_dv_end", 32'(data_valid), 32'h0);

    // Reset in the first hold cycle drops the grant and the pointer
    req_data[1] = 4'h7;
    req = 4'b0010;
    push(1, 4'b0010, 4'h7, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check_reset_outputs("midhold");
    rst = 1'b0;
    req_data[1] = 4'h9;
    req_data[2] = 4'hA;
    req_data[3] = 4'hC;
    req = 4'b1110;
    push(1, 4'b0010, 4'h9, 1'b1);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check("midhold_dv_end", 32'(data_valid), 32'h0);

    // N_REQ=3, HOLD_CYCLES=1: alternating grants every cycle
    rst3 = 1'b0;
    req_data3 = '0;
    req_data3[0] = 4'h5;
    req_data3[1] = 4'h6;
    req3 = 3'b011;
    for (int k = 0; k < 3; k++) begin
      push3(0, 3'b001, 4'h5, 1'b1);
      push3(1, 3'b010, 4'h6, 1'b0);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("n3_dv", 32'(data_valid3), 32'h1);
      if (k == 6) req3 = '0;
    end
    @(negedge clk);
    check("n3_dv_end", 32'(data_valid3), 32'h0);

    // Bounded drain of both scoreboards
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0 && exp3_q.size() == 0) break;
      @(negedge clk);
    end
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("exp3_q_drained", 32'(exp3_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
